// File: rtl/snake_motion_ctrl.sv
// Snake motion controller: direction/key handling, step timing, body shift,
// growth and wall/body collision detection for a grid-based snake game.
// Optional build macro SNAKE_WRAP_EN: the head wraps to the opposite edge
// instead of hitting the wall; hit_wall then never asserts.
module snake_motion_ctrl #(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int MAX_LEN     = 16,
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key1_press,
    input  logic                   key2_press,
    input  logic                   key3_press,
    input  logic                   key4_press,
    input  logic [1:0]             game_status,
    input  logic                   restart,
    input  logic                   grow,
    output logic                   step,
    output logic                   hit_wall,
    output logic                   hit_body,
    output logic [5:0]             head_x,
    output logic [4:0]             head_y,
    output logic [4:0]             length,
    output logic [6*MAX_LEN-1:0]   body_x,
    output logic [5*MAX_LEN-1:0]   body_y
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);
    localparam logic [5:0] X_MAX   = 6'(GRID_W - 1);
    localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);
    localparam logic [1:0] ST_PLAY = 2'b10;

    // Direction encoding: flipping bit 0 gives the exact reverse direction.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

`ifdef SNAKE_WRAP_EN
    localparam logic WALL_EN = 1'b0;
`else
    localparam logic WALL_EN = 1'b1;
`endif

    logic [5:0]       seg_x_q [MAX_LEN];
    logic [4:0]       seg_y_q [MAX_LEN];
    logic [4:0]       len_q;
    logic [1:0]       dir_q, pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             grow_pend_q, hit_wall_q, hit_body_q;

    logic             key_vld;
    logic [1:0]       key_dir;
    logic             run, step_fire;
    logic [5:0]       nhx;
    logic [4:0]       nhy;
    logic             off_grid, wall_hit, body_hit, grows;
    logic [4:0]       body_lim;

    function automatic logic [5:0] init_x(input int i);
        case (i)
            0:       return 6'd20;
            1:       return 6'd19;
            2:       return 6'd18;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [4:0] init_y(input int i);
        return (i < 3) ? 5'd15 : 5'd0;
    endfunction

    // Key arbitration (key1 highest) and reverse-direction filter vs applied direction.
    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_RIGHT;
        if (key1_press)      key_dir = DIR_UP;
        else if (key2_press) key_dir = DIR_DOWN;
        else if (key3_press) key_dir = DIR_LEFT;
        else if (key4_press) key_dir = DIR_RIGHT;
        else                 key_vld = 1'b0;
        pend_d = pend_q;
        if (key_vld && (key_dir != (dir_q ^ 2'b01))) pend_d = key_dir;
    end

    assign run       = (game_status == ST_PLAY) && !hit_wall_q && !hit_body_q;
    assign step_fire = run && (cnt_q == CNT_MAX) && !restart;

    // Next head position; off_grid flags a move across an edge (wrapped coordinate kept).
    always_comb begin
        nhx      = seg_x_q[0];
        nhy      = seg_y_q[0];
        off_grid = 1'b0;
        case (pend_q)
            DIR_UP: begin
                if (seg_y_q[0] == 5'd0) begin off_grid = 1'b1; nhy = Y_MAX; end
                else nhy = seg_y_q[0] - 5'd1;
            end
            DIR_DOWN: begin
                if (seg_y_q[0] >= Y_MAX) begin off_grid = 1'b1; nhy = 5'd0; end
                else nhy = seg_y_q[0] + 5'd1;
            end
            DIR_LEFT: begin
                if (seg_x_q[0] == 6'd0) begin off_grid = 1'b1; nhx = X_MAX; end
                else nhx = seg_x_q[0] - 6'd1;
            end
            default: begin
                if (seg_x_q[0] >= X_MAX) begin off_grid = 1'b1; nhx = 6'd0; end
                else nhx = seg_x_q[0] + 6'd1;
            end
        endcase
    end

    assign wall_hit = off_grid & WALL_EN;

    // Body collision: the tail vacates its cell unless this step grows the snake.
    always_comb begin
        grows    = (grow_pend_q | grow) && (len_q < LEN_MAX);
        body_lim = grows ? (len_q - 5'd1) : (len_q - 5'd2);
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) <= body_lim) && (seg_x_q[i] == nhx) && (seg_y_q[i] == nhy))
                body_hit = 1'b1;
        end
    end

    // Game state: reinitialise on reset/restart, otherwise advance on step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            len_q       <= 5'd3;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            cnt_q       <= '0;
            grow_pend_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_body_q  <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            len_q       <= 5'd3;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            cnt_q       <= '0;
            grow_pend_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_body_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (grow) grow_pend_q <= 1'b1;
            if (run) cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
            if (step_fire) begin
                dir_q <= pend_q;
                if (wall_hit) begin
                    hit_wall_q <= 1'b1;
                end else if (body_hit) begin
                    hit_body_q <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x_q[i] <= seg_x_q[i-1];
                        seg_y_q[i] <= seg_y_q[i-1];
                    end
                    seg_x_q[0]  <= nhx;
                    seg_y_q[0]  <= nhy;
                    if (grows) len_q <= len_q + 5'd1;
                    grow_pend_q <= 1'b0;
                end
            end
        end
    end

    // Segment outputs; inactive segments read as zero.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            body_x[6*i +: 6] = (5'(i) < len_q) ? seg_x_q[i] : 6'd0;
            body_y[5*i +: 5] = (5'(i) < len_q) ? seg_y_q[i] : 5'd0;
        end
    end

    assign step     = step_fire;
    assign hit_wall = hit_wall_q;
    assign hit_body = hit_body_q;
    assign head_x   = seg_x_q[0];
    assign head_y   = seg_y_q[0];
    assign length   = len_q;

endmodule

// File: doc/snake_motion_ctrl.md
SNAKE_MOTION_CTRL -- requirements
Module: snake_motion_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 12_500_000: clk cycles per snake step.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum segment count, including head.
REQ-003 SHALL have parameters GRID_W, default 40, and GRID_H, default 30: cell grid size.
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports key1_press/key2_press/key3_press/key4_press  in  1 each  single-cycle pulses: up/down/left/right.
REQ-007 SHALL have port game_status  in  2  00 RESTART, 01 START, 10 PLAY, 11 DIE.
REQ-008 SHALL have port restart  in  1  synchronous reinitialise request, level.
REQ-009 SHALL have port grow  in  1  single-cycle pulse: apple eaten.
REQ-010 SHALL have port step  out  1  one-cycle pulse on each evaluated move.
REQ-011 SHALL have ports hit_wall and hit_body  out  1 each  sticky collision flags.
REQ-012 SHALL have port head_x  out  6  head column; head_y  out  5  head row.
REQ-013 SHALL have port length  out  5  active segment count.
REQ-014 SHALL have ports body_x  out  6*MAX_LEN and body_y  out  5*MAX_LEN  segment i at bits [6i+5:6i] / [5i+4:5i]; segment 0 is the head.

Function
REQ-015 SHALL hold a 2-bit direction register and a pending-direction register; any key pulse updates pending at any game_status.
REQ-016 SHALL, for simultaneous key pulses, apply priority key1>key2>key3>key4.
REQ-017 SHALL ignore a key requesting the exact reverse of the current direction, i.e. compared against the applied direction, not pending.
REQ-018 SHALL run the step counter only while game_status==PLAY and both hit flags are 0; otherwise it holds its value.
REQ-019 SHALL pulse step for one cycle when the counter reaches STEP_CYCLES-1; the counter wraps to 0 on the same edge.
REQ-020 SHALL, on the step cycle, copy pending to direction and compute next head = head ±1 in x (left/right) or y (up/down; up = y-1).
REQ-021 SHALL set hit_wall at the edge ending the step cycle if next head x<0, x>=GRID_W, y<0 or y>=GRID_H; no movement that step.
REQ-022 SHALL set hit_body at that same edge if next head equals any segment 1..length-2, or 1..length-1 when growing; no movement that step.
REQ-023 SHALL, when both wall and body conditions hold, set hit_wall only.
REQ-024 SHALL otherwise shift segment i to i+1 for all i and load the next head into segment 0, all on the same edge.
REQ-025 SHALL latch a grow pulse into a grow-pending flag; a grow pulse coincident with a step applies to that step.
REQ-026 SHALL increment length by 1 on a non-colliding step with grow-pending set and length<MAX_LEN, then clear grow-pending; at MAX_LEN it clears the flag without growth.
REQ-027 SHALL keep hit_wall/hit_body at 1 until restart or reset.
REQ-028 SHALL drive segments at index >= length to 0.

Reset
REQ-029 SHALL, on rst low or restart high, set head to (20,15), segment 1 to (19,15), segment 2 to (18,15), length 3, direction and pending to right, and step counter to 0.
REQ-030 SHALL, in the same condition, clear grow-pending, step, hit_wall and hit_body; restart has priority over step and key events in the same cycle.
REQ-031 SHALL give rst mid-step immediate effect; no partial shift is retained.

Configuration
REQ-032 SHALL, with SNAKE_WRAP_EN defined, wrap an out-of-range next head to the opposite edge (x=-1→GRID_W-1, x=GRID_W→0; likewise y); hit_wall then remains 0 permanently.
REQ-033 SHALL, without SNAKE_WRAP_EN, behave per REQ-021.

Verification (STEP_CYCLES=4)
REQ-034 SHALL cover: reset, then PLAY for 8 cycles, no keys -> exactly 2 step pulses; head (22,15); length 3; no hits.
REQ-035 SHALL cover: in PLAY, key3 (left) pulse while moving right -> ignored; head keeps moving +x.
REQ-036 SHALL cover: key1 pulse, then one step -> head y decrements by 1; x unchanged.
REQ-037 SHALL cover: grow pulse, then one step -> length 4; previous tail coordinate retained in segment 3.
REQ-038 SHALL cover: head driven to x=39 moving right, then a step -> hit_wall=1 and head stays (39,y); with SNAKE_WRAP_EN -> head (0,y) and hit_wall=0.
REQ-039 SHALL cover: length 5, keys up/left/down timed for a U-turn into the body -> hit_body=1; then restart pulse -> head (20,15), length 3, flags 0.
